// File: rtl/keynsham_bootrom_arbiter.sv
// ---------------------------------------------------------------------------
// keynsham_bootrom_arbiter
//
// Shares one single-port synchronous boot ROM between the CPU instruction
// fetch port and the data port. Read accesses are serialised with
// round-robin arbitration; each granted read returns its word together with
// a one-cycle ack pulse. Data-port writes never reach the ROM: they are
// dropped and acknowledged on the next cycle with zero read data.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req, i_addr         fetch request (held until i_ack) and byte address
//   i_data, i_ack         fetch read data and one-cycle completion pulse
//   d_access, d_cs, d_wr  data cycle in progress, ROM select, write flag
//   d_addr, d_bytesel     data byte address, byte enables (unused)
//   d_data, d_ack         data read data and one-cycle completion pulse
//   mem_en, mem_addr      ROM read enable and word address
//   mem_q                 ROM read data
// ---------------------------------------------------------------------------
`default_nettype none

module keynsham_bootrom_arbiter #(
    parameter int ADDR_BITS   = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic [31:0]          i_data,
    output logic                 i_ack,
    input  logic                 d_access,
    input  logic                 d_cs,
    input  logic                 d_wr,
    input  logic [31:0]          d_addr,
    input  logic [3:0]           d_bytesel,
    output logic [31:0]          d_data,
    output logic                 d_ack,
    output logic                 mem_en,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [31:0]          mem_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // The wait counter starts at MEM_LATENCY-1 so READ lasts MEM_LATENCY cycles.
    localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

    state_t               state_r;
    port_t                grant_r;
    port_t                last_grant_r;
    logic [1:0]           cnt_r;

    logic                 ireq_s;
    logic                 dreq_s;
    logic                 drd_s;
    logic                 dwr_s;
    logic                 any_rd_s;
    port_t                win_s;
    logic [ADDR_BITS-1:0] win_addr_s;
    logic                 unused_s;

    // Ack terms mask a held request so it is not re-granted in its own ack cycle.
    assign ireq_s   = i_req & ~i_ack;
    assign dreq_s   = d_access & d_cs & ~d_ack;
    assign drd_s    = dreq_s & ~d_wr;
    assign dwr_s    = dreq_s & d_wr;
    assign any_rd_s = ireq_s | drd_s;

    // Byte enables and out-of-range address bits have no effect (ROM aliases).
    assign unused_s = ^{d_bytesel, i_addr[31:ADDR_BITS+2], i_addr[1:0],
                        d_addr[31:ADDR_BITS+2], d_addr[1:0]};

    // Round-robin winner among read requesters: on a tie the port not granted last wins.
    always_comb begin
        win_s      = PORT_I;
        win_addr_s = i_addr[ADDR_BITS+1:2];
        if (ireq_s && drd_s) begin
            win_s = (last_grant_r == PORT_D) ? PORT_I : PORT_D;
        end else if (drd_s) begin
            win_s = PORT_D;
        end else begin
            win_s = PORT_I;
        end
        if (win_s == PORT_D) begin
            win_addr_s = d_addr[ADDR_BITS+1:2];
        end else begin
            win_addr_s = i_addr[ADDR_BITS+1:2];
        end
    end

    // Arbitration FSM with registered ROM controls, acks and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            grant_r      <= PORT_I;
            last_grant_r <= PORT_D;
            cnt_r        <= 2'd0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_data       <= 32'h0000_0000;
            d_data       <= 32'h0000_0000;
            mem_en       <= 1'b0;
            mem_addr     <= {ADDR_BITS{1'b0}};
        end else begin
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;

            // Writes are dropped but still acknowledged, independent of any read.
            if (dwr_s) begin
                d_ack  <= 1'b1;
                d_data <= 32'h0000_0000;
            end

            case (state_r)
                IDLE, DONE: begin
                    if (any_rd_s) begin
                        state_r      <= READ;
                        mem_en       <= 1'b1;
                        mem_addr     <= win_addr_s;
                        grant_r      <= win_s;
                        last_grant_r <= win_s;
                        cnt_r        <= CNT_INIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (cnt_r != 2'd0) begin
                        cnt_r <= cnt_r - 2'd1;
                    end else begin
                        state_r <= DONE;
                        if (grant_r == PORT_D) begin
                            d_data <= mem_q;
                            d_ack  <= 1'b1;
                        end else begin
                            i_data <= mem_q;
                            i_ack  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keynsham_bootrom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_keynsham_bootrom_arbiter
//
// Two arbiter instances share clock and reset: u1 with MEM_LATENCY=1 serves
// most scenarios, u3 with MEM_LATENCY=3 covers the long-latency fetch. Each
// has a small ROM model that returns a marker word unless the read was
// enabled at the right time. Stimulus pushes {expected word, expected ack
// cycle} into per-port queues; a negedge monitor pops and compares on every
// ack it sees.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_keynsham_bootrom_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t qi1[$];
    exp_t qd1[$];
    exp_t qi3[$];
    exp_t e;

    // u1 signals
    logic        i_req1 = 1'b0, d_access1 = 1'b0, d_cs1 = 1'b0, d_wr1 = 1'b0;
    logic [31:0] i_addr1 = 32'h0, d_addr1 = 32'h0;
    logic [3:0]  d_bytesel1 = 4'hF;
    logic [31:0] i_data1, d_data1, mem_q1;
    logic        i_ack1, d_ack1, mem_en1;
    logic [9:0]  mem_addr1;

    // u3 signals
    logic        i_req3 = 1'b0, d_access3 = 1'b0, d_cs3 = 1'b0, d_wr3 = 1'b0;
    logic [31:0] i_addr3 = 32'h0, d_addr3 = 32'h0;
    logic [3:0]  d_bytesel3 = 4'h0;
    logic [31:0] i_data3, d_data3, mem_q3;
    logic        i_ack3, d_ack3, mem_en3;
    logic [9:0]  mem_addr3;
    logic [31:0] s3, p1 = 32'h0, p2 = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] romw(input int a);
        return 32'hC0DE_0000 + 32'(a) * 32'h0000_0111;
    endfunction

    // ROM models: data only appears for an enabled read, delayed to the latency.
    always_comb mem_q1 = mem_en1 ? romw(int'(mem_addr1)) : 32'hBAD0_0000;
    always_comb s3 = mem_en3 ? romw(int'(mem_addr3)) : 32'hBAD0_0000;
    always @(posedge clk) begin
        p1 <= s3;
        p2 <= p1;
    end
    assign mem_q3 = p2;

    keynsham_bootrom_arbiter #(.ADDR_BITS(10), .MEM_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req1), .i_addr(i_addr1), .i_data(i_data1), .i_ack(i_ack1),
        .d_access(d_access1), .d_cs(d_cs1), .d_wr(d_wr1), .d_addr(d_addr1),
        .d_bytesel(d_bytesel1), .d_data(d_data1), .d_ack(d_ack1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_q(mem_q1)
    );

    keynsham_bootrom_arbiter #(.ADDR_BITS(10), .MEM_LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req3), .i_addr(i_addr3), .i_data(i_data3), .i_ack(i_ack3),
        .d_access(d_access3), .d_cs(d_cs3), .d_wr(d_wr3), .d_addr(d_addr3),
        .d_bytesel(d_bytesel3), .d_data(d_data3), .d_ack(d_ack3),
        .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_q(mem_q3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ack must match the head of its port's expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_ack1) begin
                if (qi1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL u1_i_ack_unexpected: ack at cycle %0d data %h, want no ack", cyc, i_data1);
                end else begin
                    e = qi1.pop_front();
                    chk("u1_i_data", i_data1, e.data);
                    chk("u1_i_ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (d_ack1) begin
                if (qd1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL u1_d_ack_unexpected: ack at cycle %0d data %h, want no ack", cyc, d_data1);
                end else begin
                    e = qd1.pop_front();
                    chk("u1_d_data", d_data1, e.data);
                    chk("u1_d_ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (i_ack3) begin
                if (qi3.size() == 0) begin
                    total++; bad++;
                    $display("FAIL u3_i_ack_unexpected: ack at cycle %0d data %h, want no ack", cyc, i_data3);
                end else begin
                    e = qi3.pop_front();
                    chk("u3_i_data", i_data3, e.data);
                    chk("u3_i_ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (d_ack3) begin
                total++; bad++;
                $display("FAIL u3_d_ack_unexpected: ack at cycle %0d, want no ack", cyc);
            end
        end
    end

    // Requesters: raise the request, hold it until the ack is seen, then drop it.
    task automatic fetch1(input logic [31:0] a);
        bit got = 1'b0;
        i_req1 = 1'b1; i_addr1 = a;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (i_ack1) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL u1_fetch_timeout: no i_ack for %h, want ack within 40 cycles", a);
        end
        i_req1 = 1'b0;
    endtask

    task automatic dread1(input logic [31:0] a);
        bit got = 1'b0;
        d_access1 = 1'b1; d_cs1 = 1'b1; d_wr1 = 1'b0; d_addr1 = a;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (d_ack1) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL u1_dread_timeout: no d_ack for %h, want ack within 40 cycles", a);
        end
        d_access1 = 1'b0; d_cs1 = 1'b0;
    endtask

    task automatic dwrite1(input logic [31:0] a);
        bit got = 1'b0;
        d_access1 = 1'b1; d_cs1 = 1'b1; d_wr1 = 1'b1; d_addr1 = a;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (d_ack1) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL u1_dwrite_timeout: no d_ack for %h, want ack within 40 cycles", a);
        end
        d_access1 = 1'b0; d_cs1 = 1'b0; d_wr1 = 1'b0;
    endtask

    task automatic fetch3(input logic [31:0] a);
        bit got = 1'b0;
        i_req3 = 1'b1; i_addr3 = a;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (i_ack3) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL u3_fetch_timeout: no i_ack for %h, want ack within 40 cycles", a);
        end
        i_req3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_u1_i_data", i_data1, 32'h0);
        chk("rst_u1_d_data", d_data1, 32'h0);
        chk("rst_u1_ctl", {29'd0, i_ack1, d_ack1, mem_en1}, 32'h0);
        chk("rst_u1_mem_addr", {22'd0, mem_addr1}, 32'h0);
        chk("rst_u3_ctl", {29'd0, i_ack3, d_ack3, mem_en3}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Tie straight after reset: fetch wins first, data follows with no idle cycle.
        c = cyc;
        qi1.push_back('{romw(0), c + 2});
        qd1.push_back('{romw(2), c + 4});
        fork
            fetch1(32'h0000_0000);
            dread1(32'h0000_0008);
        join
        tick();

        // Both ports held for 8 accesses: strict alternation, each port every 4 cycles.
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            qi1.push_back('{romw(64 + k), c + 2 + 4 * k});
            qd1.push_back('{romw(128 + k), c + 4 + 4 * k});
        end
        fork
            begin
                for (int k = 0; k < 4; k++) fetch1(32'h0000_0100 + 32'(4 * k));
            end
            begin
                for (int k = 0; k < 4; k++) dread1(32'h0000_0200 + 32'(4 * k));
            end
        join
        tick();

        // Lone fetch at 0x10: mem_en/mem_addr next cycle, ack two cycles after request.
        c = cyc;
        qi1.push_back('{romw(4), c + 2});
        fork
            fetch1(32'h0000_0010);
            begin
                tick();
                chk("t1_mem_en", {31'd0, mem_en1}, 32'h1);
                chk("t1_mem_addr", {22'd0, mem_addr1}, 32'h4);
            end
        join
        chk("d_data_hold", d_data1, romw(131));
        tick();

        // Upper address bits ignored: 0xABCDE01C aliases word 7.
        c = cyc;
        qi1.push_back('{romw(7), c + 2});
        fetch1(32'hABCD_E01C);
        tick();

        // Write concurrent with a fetch: write acks after 1 cycle with zero data.
        c = cyc;
        qd1.push_back('{32'h0, c + 1});
        qi1.push_back('{romw(9), c + 2});
        fork
            dwrite1(32'h0000_0030);
            fetch1(32'h0000_0024);
            begin
                tick();
                chk("t4_mem_en", {31'd0, mem_en1}, 32'h1);
                chk("t4_mem_addr", {22'd0, mem_addr1}, 32'h9);
            end
        join
        tick();

        // Data access without chip select: no ROM read, no ack.
        d_access1 = 1'b1; d_cs1 = 1'b0; d_wr1 = 1'b0; d_addr1 = 32'h0000_0050;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("nocs_mem_en", {31'd0, mem_en1}, 32'h0);
        end
        d_access1 = 1'b0;
        tick();

        // Lone write never enables the ROM.
        c = cyc;
        qd1.push_back('{32'h0, c + 1});
        fork
            dwrite1(32'h0000_0034);
            begin
                tick();
                chk("wr_mem_en", {31'd0, mem_en1}, 32'h0);
            end
        join
        tick();

        // MEM_LATENCY=3: ack 4 cycles after request, mem_en a single-cycle pulse.
        c = cyc;
        qi3.push_back('{romw(7), c + 4});
        fork
            fetch3(32'h0000_001C);
            begin
                tick();
                chk("t5_mem_en_c1", {31'd0, mem_en3}, 32'h1);
                tick();
                chk("t5_mem_en_c2", {31'd0, mem_en3}, 32'h0);
                tick();
                chk("t5_mem_en_c3", {31'd0, mem_en3}, 32'h0);
            end
        join
        tick();

        // Reset during READ: outputs clear at once, abandoned reads never ack.
        i_req1 = 1'b1; i_addr1 = 32'h0000_0040;
        i_req3 = 1'b1; i_addr3 = 32'h0000_0040;
        tick();
        chk("t6_pre_mem_en", {31'd0, mem_en1}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_u1_i_data", i_data1, 32'h0);
        chk("t6_u1_ctl", {29'd0, i_ack1, d_ack1, mem_en1}, 32'h0);
        chk("t6_u1_mem_addr", {22'd0, mem_addr1}, 32'h0);
        chk("t6_u3_i_data", i_data3, 32'h0);
        chk("t6_u3_ctl", {29'd0, i_ack3, d_ack3, mem_en3}, 32'h0);
        chk("t6_u3_mem_addr", {22'd0, mem_addr3}, 32'h0);
        i_req1 = 1'b0; i_req3 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();

        // Re-issued requests: full latency, and the fetch port wins the first tie again.
        c = cyc;
        qi1.push_back('{romw(16), c + 2});
        qd1.push_back('{romw(18), c + 4});
        qi3.push_back('{romw(17), c + 4});
        fork
            fetch1(32'h0000_0040);
            dread1(32'h0000_0048);
            fetch3(32'h0000_0044);
        join
        tick(); tick(); tick();

        chk("u1_i_queue_empty", 32'(qi1.size()), 32'h0);
        chk("u1_d_queue_empty", 32'(qd1.size()), 32'h0);
        chk("u3_i_queue_empty", 32'(qi3.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
